// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: sequential inverse AES key schedule.
//
// Loaded with the last Nk words of an expanded key, it walks the expansion
// backwards one word per cycle and hands out round keys Nr..0 over a
// valid/ready handshake, so the full schedule is never stored.
//
// Parameters:
//   Nk        key length in 32-bit words (4, 6 or 8); Nr = Nk + 6
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     load request, sampled only in IDLE
//   key_in    w[4(Nr+1)-Nk] .. w[4(Nr+1)-1], lowest-index word at [31:0]
//   busy      high in every state except IDLE
//   rk_valid  round key presented
//   rk_ready  consumer accepts the round key
//   rk_out    round key r = w[4r..4r+3], w[4r] at [31:0]
//   rk_round  index r of the key on rk_out
//   rk_last   high with rk_valid when r == 0
//   done      one-cycle pulse after round key 0 is accepted
//
// Build option:
//   AES_INV_KS_ZEROIZE_EN  clear the key window in the FIN cycle
module aes_inv_key_sched #(
  parameter int Nk = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*Nk-1:0]  key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [127:0]      rk_out,
  output logic [3:0]        rk_round,
  output logic              rk_last,
  output logic              done
);
  localparam int         NR   = Nk + 6;
  localparam int         NW   = 4 * (NR + 1);
  localparam logic [5:0] B0   = 6'(NW - Nk);
  localparam logic [3:0] R0   = 4'(NR);
  localparam logic [2:0] P0   = 3'((NW - 1) % Nk);
  localparam logic [3:0] J0   = 4'((NW - 1) / Nk);
  localparam logic [2:0] PTOP = 3'(Nk - 1);

  generate
    if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
      $error("aes_inv_key_sched: Nk must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EMIT, STEP, FIN} state_t;

  state_t                state_q, state_d;
  logic [Nk-1:0][31:0]   win;   // w[b .. b+Nk-1], win[0] = w[b]
  logic [5:0]            b;
  logic [3:0]            r;
  logic [2:0]            p;     // (b+Nk-1) mod Nk
  logic [3:0]            j;     // (b+Nk-1) / Nk

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] acc, x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, 0 maps to 0) plus affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    t = x;
    for (int i = 0; i < 6; i++) t = gf_mul(gf_mul(t, t), x);
    t = gf_mul(t, t);
    return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^
           {t[3:0], t[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Backward step. Both SubWord cases read w[i-1]; SubWord and RotWord
  // commute bytewise, so one S-box word serves both and the rotate follows.
  logic [31:0] prev, sub, temp, new_w;
  assign prev = win[Nk-2];
  assign sub  = {sbox(prev[31:24]), sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0])};

  always_comb begin
    temp = prev;
    if (p == 3'd0)
      temp = {sub[23:0], sub[31:24]} ^ {rcon(j), 24'h0};
    else if (Nk == 8 && p == 3'd4)
      temp = sub;
  end

  assign new_w = win[Nk-1] ^ temp;

  // Window offset of round key r: o = 4r - b, always 0..Nk-4.
  logic [6:0] r4, b7, o7;
  assign r4 = {1'b0, r, 2'b00};
  assign b7 = {1'b0, b};
  assign o7 = r4 - b7;

  always_comb begin
    rk_out = '0;
    for (int k = 0; k <= Nk - 4; k++)
      if (o7 == 7'(k))
        for (int q = 0; q < 4; q++) rk_out[32*q +: 32] = win[k+q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = EMIT;
      EMIT: if (rk_ready) begin
        if (r == 4'd0)                 state_d = FIN;
        else if ((r4 - 7'd4) >= b7)    state_d = EMIT;  // next key already in window
        else                           state_d = STEP;
      end
      STEP: if (r4 >= (b7 - 7'd1))     state_d = EMIT;  // post-step window covers key r
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
      b   <= '0;
      r   <= '0;
      p   <= '0;
      j   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          win <= key_in;
          b   <= B0;
          r   <= R0;
          p   <= P0;
          j   <= J0;
        end
        EMIT: if (rk_ready && r != 4'd0) r <= r - 4'd1;
        STEP: begin
          win <= {win[Nk-2:0], new_w};
          b   <= b - 6'd1;
          if (p == 3'd0) begin
            p <= PTOP;
            j <= j - 4'd1;
          end else begin
            p <= p - 3'd1;
          end
        end
        FIN: begin
`ifdef AES_INV_KS_ZEROIZE_EN
          win <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign rk_last  = (state_q == EMIT) && (r == 4'd0);
  assign done     = (state_q == FIN);
  assign rk_round = r;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Testbench for aes_inv_key_sched: three instances (Nk = 4, 6, 8) driven
// from FIPS-197 keys; a forward key-expansion model fills a scoreboard that
// is drained as round keys are handshaken.
module tb_aes_inv_key_sched;
  logic         clk, rst_n;
  logic         start    [3];
  logic         rk_ready [3];
  logic [255:0] key_in   [3];
  logic         busy     [3];
  logic         rk_valid [3];
  logic         rk_last  [3];
  logic         done     [3];
  logic [127:0] rk_out   [3];
  logic [3:0]   rk_round [3];

  int checks = 0;
  int errors = 0;

  typedef struct { logic [127:0] key; logic [3:0] round; logic last; } exp_t;
  exp_t        sbq [$];
  logic [31:0] mw  [3][60];

  aes_inv_key_sched #(.Nk(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(key_in[0][127:0]),
    .busy(busy[0]), .rk_valid(rk_valid[0]), .rk_ready(rk_ready[0]),
    .rk_out(rk_out[0]), .rk_round(rk_round[0]), .rk_last(rk_last[0]), .done(done[0]));

  aes_inv_key_sched #(.Nk(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(key_in[1][191:0]),
    .busy(busy[1]), .rk_valid(rk_valid[1]), .rk_ready(rk_ready[1]),
    .rk_out(rk_out[1]), .rk_round(rk_round[1]), .rk_last(rk_last[1]), .done(done[1]));

  aes_inv_key_sched #(.Nk(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(key_in[2][255:0]),
    .busy(busy[2]), .rk_valid(rk_valid[2]), .rk_ready(rk_ready[2]),
    .rk_out(rk_out[2]), .rk_round(rk_round[2]), .rk_last(rk_last[2]), .done(done[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed nothing expected event", tag);
  endtask

  // Forward-expansion model (FIPS-197 5.2), independent of the DUT's method.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) acc ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      m = m >> 1;
    end
    return acc;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = '0;
    for (int y = 1; y < 256; y++)
      if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    s = 8'h63;
    for (int n = 0; n < 5; n++) s ^= (inv << n) | (inv >> (8 - n));
    return s;
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] w);
    return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] m_rcon(input int idx);
    logic [7:0] rc;
    rc = 8'h01;
    for (int q = 1; q < idx; q++) rc = m_mul(rc, 8'h02);
    return rc;
  endfunction

  task automatic expand(input int k, input int nk, input logic [255:0] key);
    int nw = 4 * (nk + 7);
    for (int q = 0; q < nk; q++) mw[k][q] = key[32*q +: 32];
    for (int i = nk; i < nw; i++) begin
      logic [31:0] t;
      t = mw[k][i-1];
      if (i % nk == 0)               t = m_sub({t[23:0], t[31:24]}) ^ {m_rcon(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = m_sub(t);
      mw[k][i] = mw[k][i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rkey(input int k, input int r);
    return {mw[k][4*r+3], mw[k][4*r+2], mw[k][4*r+1], mw[k][4*r]};
  endfunction

  // Called mid-cycle in IDLE (that cycle is cycle 0); returns in the FIN cycle.
  task automatic run_pass(input int k, input int stall_round, input int pulse_cyc, input int exp_done);
    int nk = 4 + 2 * k;
    int nr = nk + 6;
    int nw = 4 * (nr + 1);
    int cyc = 0, stall_left = 0, popped = 0;
    bit stalled = 0, hold_chk = 0, got_done = 0;
    logic [127:0] held = '0;
    exp_t e;
    key_in[k] = '0;
    for (int q = 0; q < nk; q++) key_in[k][32*q +: 32] = mw[k][nw-nk+q];
    for (int r = nr; r >= 0; r--) begin
      e.key = rkey(k, r); e.round = 4'(r); e.last = (r == 0);
      sbq.push_back(e);
    end
    start[k] = 1'b1;
    rk_ready[k] = 1'b1;
    while (!got_done && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
      start[k] = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) key_in[k] = {8{$urandom()}};
      if (cyc == 1) begin
        check("first_valid", 128'(rk_valid[k]), 128'(1));
        check("first_round", 128'(rk_round[k]), 128'(nr));
        if (k == 0) check("aes128_first_key", rk_out[k], 128'hb6630ca6e13f0cc8c9ee2589d014f9a8);
      end
      if (hold_chk) begin
        check("stall_hold_key", rk_out[k], held);
        check("stall_hold_round", 128'(rk_round[k]), 128'(stall_round));
      end
      hold_chk = 0;
      if (!stalled && rk_valid[k] && int'(rk_round[k]) == stall_round) begin
        stalled = 1; stall_left = 5; held = rk_out[k];
      end
      if (stall_left > 0) begin
        rk_ready[k] = 1'b0; stall_left--; hold_chk = 1;
      end else begin
        rk_ready[k] = 1'b1;
      end
      if (rk_valid[k] && rk_ready[k]) begin
        if (sbq.size() == 0) fail_now("scoreboard_underflow");
        else begin
          e = sbq.pop_front();
          popped++;
          check("key", rk_out[k], e.key);
          check("round", 128'(rk_round[k]), 128'(e.round));
          check("last", 128'(rk_last[k]), 128'(e.last));
          if (e.round == 4'd0 && k == 0) check("aes128_r0", rk_out[k], 128'h09cf4f3cabf7158828aed2a62b7e1516);
          if (e.round == 4'd0 && k == 1) check("aes192_r0", rk_out[k], 128'h809079e5c810f32bda0e64528e73b0f7);
          if (e.round == 4'd0 && k == 2) check("aes256_r0", rk_out[k], 128'h857d77812b73aef015ca71be603deb10);
          if (e.round == 4'd1 && k == 2) check("aes256_r1", rk_out[k], 128'h0914dff42d9810a33b6108d71f352c07);
        end
      end
      if (done[k]) begin
        got_done = 1;
        check("done_cycle", 128'(cyc), 128'(exp_done));
        check("keys_emitted", 128'(popped), 128'(nr + 1));
      end
    end
    if (!got_done) fail_now("done_timeout");
    sbq.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; rk_ready[k] = 1'b1; key_in[k] = '0;
    end
    expand(0, 4, {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516});
    expand(1, 6, {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b,
                  32'hda0e6452, 32'h8e73b0f7});
    expand(2, 8, {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                  32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10});
    #12;
    for (int k = 0; k < 3; k++) begin
      check("rst_busy", 128'(busy[k]), 128'(0));
      check("rst_valid", 128'(rk_valid[k]), 128'(0));
      check("rst_done", 128'(done[k]), 128'(0));
      check("rst_out", rk_out[k], 128'(0));
      check("rst_round", 128'(rk_round[k]), 128'(0));
    end
    @(negedge clk); rst_n = 1'b1; #1;

    // AES-128 full pass, then start held through FIN into IDLE.
    run_pass(0, -1, -1, 52);
    start[0] = 1'b1;
    @(negedge clk); #1;
    check("fin_start_ignored_busy", 128'(busy[0]), 128'(0));
    check("idle_done_low", 128'(done[0]), 128'(0));
`ifdef AES_INV_KS_ZEROIZE_EN
    check("idle_zeroized", rk_out[0], 128'(0));
`else
    check("idle_window_kept", rk_out[0], rkey(0, 0));
`endif
    @(negedge clk); #1;
    start[0] = 1'b0;
    check("restart_valid", 128'(rk_valid[0]), 128'(1));
    check("restart_round", 128'(rk_round[0]), 128'(10));
    check("restart_key", rk_out[0], rkey(0, 10));
    @(negedge clk); #1;
    check("in_step_busy", 128'(busy[0]), 128'(1));
    check("in_step_valid", 128'(rk_valid[0]), 128'(0));

    // Reset in a STEP cycle: outputs clear at once, no done.
    rst_n = 1'b0; #1;
    check("midrst_busy", 128'(busy[0]), 128'(0));
    check("midrst_valid", 128'(rk_valid[0]), 128'(0));
    check("midrst_last", 128'(rk_last[0]), 128'(0));
    check("midrst_out", rk_out[0], 128'(0));
    check("midrst_round", 128'(rk_round[0]), 128'(0));
    repeat (2) begin
      @(negedge clk); #1;
      check("midrst_no_done", 128'(done[0]), 128'(0));
    end
    rst_n = 1'b1; #1;

    // Clean restart with back-pressure at round 7 and a start pulse mid-run.
    run_pass(0, 7, 33, 57);
    run_pass(1, -1, -1, 60);
    run_pass(2, -1, -1, 68);
    @(negedge clk); #1;
`ifdef AES_INV_KS_ZEROIZE_EN
    check("aes256_idle_zeroized", rk_out[2], 128'(0));
`else
    check("aes256_idle_window_kept", rk_out[2], rkey(2, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
